// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared definitions for the decode-stage hazard scoreboard:
//   - default stall latencies for the load-use and no-forwarding cases
//   - cnt_w(): width of one per-register countdown entry
//   - source-slot index constants for the packed id_src bus
package hazard_pkg;

  localparam int LOAD_USE_LAT_DEF = 1;
  localparam int NOFWD_LAT_DEF    = 2;

  localparam int SRC_RN = 0;
  localparam int SRC_RM = 1;
  localparam int SRC_RS = 2;

  // An entry must hold the larger of the two latencies, so size it for that.
  function automatic int cnt_w(input int load_use_lat, input int nofwd_lat);
    int m;
    m = (load_use_lat > nofwd_lat) ? load_use_lat : nofwd_lat;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sb_countdown.sv
// sb_countdown
// One scoreboard entry: a CNT_W-bit countdown that tells the decode stage
// how many more cycles a consumer must wait before reading the register.
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset, clears the count
//   freeze    in   hold the count (memory not ready)
//   load      in   overwrite the count with load_val
//   load_val  in   CNT_W new count from an issuing writer
//   busy      out  count is nonzero, the register is not yet readable
module sb_countdown #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             freeze,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             busy
);

  logic [CNT_W-1:0] cnt;

  // Reset beats freeze, freeze beats everything else. A load replaces the
  // decremented value so that the newest in-order writer governs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!freeze) begin
      if (load) begin
        cnt <= load_val;
      end else if (cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Decode-stage stall decision built on a per-register countdown scoreboard.
// Drives the IF/ID freeze / ID/EXE bubble (hazard) and reports when the ID
// instruction moves on (issue). Keeps a saturating count of stall cycles.
// Ports:
//   clk, rst_n        clock and synchronous active-low reset
//   fwd_en            forwarding unit active; sampled when a writer issues
//   sram_freeze       whole pipeline holds; scoreboard and counter hold
//   flush             ID instruction squashed
//   id_valid          ID holds a real instruction
//   id_src            NUM_SRC packed source indices, slot 0 in the LSBs
//   id_src_used       per-slot "operand is read"
//   id_dest, id_wb_en destination and write enable of the ID instruction
//   id_mem_read       ID instruction is a load
//   hazard            stall ID this cycle (combinational)
//   issue             ID instruction leaves ID this cycle (combinational)
//   stall_count       hazard cycles since reset, saturating
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_W        = 4,
  parameter int NUM_SRC      = 3,
  parameter int LOAD_USE_LAT = LOAD_USE_LAT_DEF,
  parameter int NOFWD_LAT    = NOFWD_LAT_DEF,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fwd_en,
  input  logic                     sram_freeze,
  input  logic                     flush,
  input  logic                     id_valid,
  input  logic [NUM_SRC*REG_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]       id_src_used,
  input  logic [REG_W-1:0]         id_dest,
  input  logic                     id_wb_en,
  input  logic                     id_mem_read,
  output logic                     hazard,
  output logic                     issue,
  output logic [STALL_CNT_W-1:0]   stall_count
);

  localparam int NUM_REGS = 2 ** REG_W;
  localparam int CNT_W    = cnt_w(LOAD_USE_LAT, NOFWD_LAT);

  localparam logic [CNT_W-1:0] LOAD_USE_VAL = CNT_W'(LOAD_USE_LAT);
  localparam logic [CNT_W-1:0] NOFWD_VAL    = CNT_W'(NOFWD_LAT);

  logic [NUM_REGS-1:0] busy;
  logic                src_busy;
  logic [CNT_W-1:0]    load_val;

  // Source compare: any read operand whose register is still counting down.
  // Uses the pre-update count, so reading your own destination never self-stalls.
  always_comb begin
    src_busy = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_src_used[i] && busy[id_src[i*REG_W +: REG_W]]) begin
        src_busy = 1'b1;
      end
    end
  end

  assign hazard = rst_n && id_valid && !flush && src_busy;
  assign issue  = rst_n && id_valid && !flush && !hazard && !sram_freeze;

  // With forwarding only loads need a wait; ALU results load zero so that a
  // younger writer clears any older pending count on the same register.
  always_comb begin
    load_val = NOFWD_VAL;
    if (fwd_en) begin
      load_val = id_mem_read ? LOAD_USE_VAL : '0;
    end
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_sb
    sb_countdown #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .freeze   (sram_freeze),
      .load     (issue && id_wb_en && (id_dest == REG_W'(r))),
      .load_val (load_val),
      .busy     (busy[r])
    );
  end

  // Frozen cycles are not stall cycles and are not counted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (hazard && !sram_freeze && (stall_count != '1)) begin
      stall_count <= stall_count + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
// Directed and random stimulus for hazard_scoreboard, checked against a
// reference model that tracks, per register, the absolute unfrozen-cycle
// time at which a consumer may read it. A second instance with a long
// no-forwarding latency drives the stall counter into saturation.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int SAT_LAT = 4095;

  logic        clk = 1'b0;
  logic        rst_n, fwd_en, sram_freeze, flush, id_valid;
  logic [11:0] id_src;
  logic [2:0]  id_src_used;
  logic [3:0]  id_dest;
  logic        id_wb_en, id_mem_read;
  logic        hazard, issue;
  logic [15:0] stall_count;

  logic        sat_rst_n;
  logic        sat_hazard, sat_issue;
  logic [15:0] sat_stall_count;

  int errors = 0;
  int checks = 0;

  int   t;
  int   ready_at [16];
  int   m_stalls;
  logic m_hazard, m_issue;

  logic       c_v, c_wb, c_mr;
  logic [3:0] c_rn, c_rm, c_rs, c_dest;
  logic [2:0] c_used;
  logic       r_fwd, r_frz, r_fl;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fwd_en      (fwd_en),
    .sram_freeze (sram_freeze),
    .flush       (flush),
    .id_valid    (id_valid),
    .id_src      (id_src),
    .id_src_used (id_src_used),
    .id_dest     (id_dest),
    .id_wb_en    (id_wb_en),
    .id_mem_read (id_mem_read),
    .hazard      (hazard),
    .issue       (issue),
    .stall_count (stall_count)
  );

  // Self-dependent writer of R0 with forwarding off: issues once, then
  // stalls SAT_LAT cycles, forever.
  hazard_scoreboard #(
    .NOFWD_LAT (SAT_LAT)
  ) dut_sat (
    .clk         (clk),
    .rst_n       (sat_rst_n),
    .fwd_en      (1'b0),
    .sram_freeze (1'b0),
    .flush       (1'b0),
    .id_valid    (1'b1),
    .id_src      (12'h000),
    .id_src_used (3'b001),
    .id_dest     (4'h0),
    .id_wb_en    (1'b1),
    .id_mem_read (1'b0),
    .hazard      (sat_hazard),
    .issue       (sat_issue),
    .stall_count (sat_stall_count)
  );

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic modelHazard();
    if (!rst_n || !id_valid || flush) return 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (id_src_used[i] && (t < ready_at[id_src[i*4 +: 4]])) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic modelReset();
    t = 0;
    m_stalls = 0;
    for (int r = 0; r < 16; r++) ready_at[r] = 0;
  endtask

  // Advance the model across one rising edge using the inputs then applied.
  task automatic modelEdge();
    int lat;
    if (!rst_n) begin
      modelReset();
    end else if (!sram_freeze) begin
      if (m_hazard && m_stalls < 65535) m_stalls++;
      if (m_issue && id_wb_en) begin
        lat = fwd_en ? (id_mem_read ? LOAD_USE_LAT_DEF : 0) : NOFWD_LAT_DEF;
        ready_at[id_dest] = t + 1 + lat;
      end
      t++;
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] rn, input logic [3:0] rm,
                               input logic [3:0] rs, input logic [2:0] used, input logic [3:0] dest,
                               input logic wb, input logic mr, input logic fwd, input logic frz,
                               input logic fl);
    id_valid                = v;
    id_src[SRC_RN*4 +: 4]   = rn;
    id_src[SRC_RM*4 +: 4]   = rm;
    id_src[SRC_RS*4 +: 4]   = rs;
    id_src_used             = used;
    id_dest                 = dest;
    id_wb_en                = wb;
    id_mem_read             = mr;
    fwd_en                  = fwd;
    sram_freeze             = frz;
    flush                   = fl;
  endtask

  task automatic checkOutput(input string tag);
    m_hazard = modelHazard();
    m_issue  = rst_n && id_valid && !flush && !m_hazard && !sram_freeze;
    checkValue({tag, "_hazard"}, {31'd0, hazard}, {31'd0, m_hazard});
    checkValue({tag, "_issue"}, {31'd0, issue}, {31'd0, m_issue});
    checkValue({tag, "_count"}, {16'd0, stall_count}, 32'(m_stalls));
  endtask

  task automatic cyc(input string tag, input logic v, input logic [3:0] rn, input logic [3:0] rm,
                     input logic [3:0] rs, input logic [2:0] used, input logic [3:0] dest,
                     input logic wb, input logic mr, input logic fwd, input logic frz,
                     input logic fl);
    applyStimulus(v, rn, rm, rs, used, dest, wb, mr, fwd, frz, fl);
    #2;
    checkOutput(tag);
    @(posedge clk);
    modelEdge();
    @(negedge clk);
  endtask

  initial begin
    sat_rst_n = 1'b0;
    rst_n     = 1'b0;
    id_src    = '0;
    applyStimulus(1'b1, 4'd1, 4'd1, 4'd1, 3'b111, 4'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    modelReset();
    @(posedge clk);
    @(negedge clk);

    // Reset with a valid instruction in ID: outputs forced low.
    cyc("rst", 1, 1, 1, 1, 3'b111, 1, 1, 1, 1, 0, 0);
    rst_n = 1'b1;

    // Load R1 then ADD reading R1 as Rn, forwarding on.
    cyc("s1_ld",   1, 0, 0, 0, 3'b000, 1, 1, 1, 1, 0, 0);
    cyc("s1_add0", 1, 1, 0, 0, 3'b001, 5, 1, 0, 1, 0, 0);
    cyc("s1_add1", 1, 1, 0, 0, 3'b001, 5, 1, 0, 1, 0, 0);
    checkValue("s1_total", {16'd0, stall_count}, 32'd1);

    // Forwarding off: SUB R2 then ORR reading R2 in Rm, distance 1 and 2.
    cyc("s2_sub",  1, 0, 0, 0, 3'b000, 2, 1, 0, 0, 0, 0);
    cyc("s2_orr0", 1, 0, 2, 0, 3'b010, 6, 1, 0, 0, 0, 0);
    cyc("s2_orr1", 1, 0, 2, 0, 3'b010, 6, 1, 0, 0, 0, 0);
    cyc("s2_orr2", 1, 0, 2, 0, 3'b010, 6, 1, 0, 0, 0, 0);
    cyc("s2_sub2", 1, 0, 0, 0, 3'b000, 2, 1, 0, 0, 0, 0);
    cyc("s2_ind",  1, 0, 0, 0, 3'b000, 7, 1, 0, 0, 0, 0);
    cyc("s2_orr3", 1, 0, 2, 0, 3'b010, 6, 1, 0, 0, 0, 0);
    cyc("s2_orr4", 1, 0, 2, 0, 3'b010, 6, 1, 0, 0, 0, 0);
    checkValue("s2_total", {16'd0, stall_count}, 32'd4);

    // Load R3, consumer frozen for 4 cycles, then one real stall.
    cyc("s3_ld", 1, 0, 0, 0, 3'b000, 3, 1, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc("s3_frz", 1, 3, 0, 0, 3'b001, 8, 1, 0, 1, 1, 0);
    checkValue("s3_frozen", {16'd0, stall_count}, 32'd4);
    cyc("s3_use0", 1, 3, 0, 0, 3'b001, 8, 1, 0, 1, 0, 0);
    cyc("s3_use1", 1, 3, 0, 0, 3'b001, 8, 1, 0, 1, 0, 0);
    checkValue("s3_total", {16'd0, stall_count}, 32'd5);

    // Two writers of R4: ALU then load -> the load's latency governs.
    cyc("s4_alu",  1, 0, 0, 0, 3'b000, 4, 1, 0, 1, 0, 0);
    cyc("s4_ld",   1, 0, 0, 0, 3'b000, 4, 1, 1, 1, 0, 0);
    cyc("s4_use0", 1, 0, 0, 4, 3'b100, 9, 1, 0, 1, 0, 0);
    cyc("s4_use1", 1, 0, 0, 4, 3'b100, 9, 1, 0, 1, 0, 0);
    // Slow writer then forwarded writer -> the zero overwrite clears it.
    cyc("s4_slow", 1, 0, 0, 0, 3'b000, 4, 1, 0, 0, 0, 0);
    cyc("s4_fast", 1, 0, 0, 0, 3'b000, 4, 1, 0, 1, 0, 0);
    cyc("s4_use2", 1, 4, 0, 0, 3'b001, 9, 1, 0, 1, 0, 0);
    // Pending load on R4 but the operand is not read.
    cyc("s4_ld2",  1, 0, 0, 0, 3'b000, 4, 1, 1, 1, 0, 0);
    cyc("s4_nouse",1, 4, 4, 4, 3'b000, 9, 1, 0, 1, 0, 0);
    checkValue("s4_total", {16'd0, stall_count}, 32'd6);

    // Flush while the consumer waits; the count keeps draining.
    cyc("s5_wr",   1, 0, 0, 0, 3'b000, 8, 1, 0, 0, 0, 0);
    cyc("s5_fl",   1, 8, 0, 0, 3'b001, 9, 1, 0, 0, 0, 1);
    cyc("s5_use0", 1, 8, 0, 0, 3'b001, 9, 1, 0, 0, 0, 0);
    cyc("s5_use1", 1, 8, 0, 0, 3'b001, 9, 1, 0, 0, 0, 0);

    // Mode sampled at issue: slow entry survives a switch to forwarding.
    cyc("s6_wr",   1, 0, 0, 0, 3'b000, 10, 1, 1, 0, 0, 0);
    cyc("s6_use0", 1, 10, 0, 0, 3'b001, 11, 0, 0, 1, 0, 0);
    cyc("s6_use1", 1, 10, 0, 0, 3'b001, 11, 0, 0, 1, 0, 0);
    cyc("s6_use2", 1, 10, 0, 0, 3'b001, 11, 0, 0, 1, 0, 0);
    checkValue("s6_total", {16'd0, stall_count}, 32'd9);

    // Reset in the middle of a 2-cycle stall.
    cyc("s7_wr",   1, 0, 0, 0, 3'b000, 12, 1, 0, 0, 0, 0);
    cyc("s7_use0", 1, 12, 0, 0, 3'b001, 13, 1, 0, 0, 0, 0);
    rst_n = 1'b0;
    cyc("s7_rst",  1, 12, 0, 0, 3'b001, 13, 1, 0, 0, 0, 0);
    rst_n = 1'b1;
    cyc("s7_use1", 1, 12, 0, 0, 3'b001, 13, 1, 0, 0, 0, 0);
    checkValue("s7_zero", {16'd0, stall_count}, 32'd0);

    // Random traffic on a few registers to force dependencies.
    c_v = 1'b0;
    c_rn = '0; c_rm = '0; c_rs = '0; c_dest = '0; c_used = '0; c_wb = 1'b0; c_mr = 1'b0;
    r_fwd = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if (!c_v || m_issue || r_fl) begin
        c_v    = ($urandom_range(0, 7) != 0);
        c_rn   = 4'($urandom_range(0, 3));
        c_rm   = 4'($urandom_range(0, 3));
        c_rs   = 4'($urandom_range(0, 3));
        c_used = 3'($urandom_range(0, 7));
        c_dest = 4'($urandom_range(0, 3));
        c_wb   = ($urandom_range(0, 3) != 0);
        c_mr   = $urandom_range(0, 1) == 1;
      end
      if ($urandom_range(0, 5) == 0) r_fwd = ~r_fwd;
      r_frz = ($urandom_range(0, 5) == 0);
      r_fl  = ($urandom_range(0, 9) == 0);
      rst_n = ($urandom_range(0, 39) != 0);
      cyc("rnd", c_v, c_rn, c_rm, c_rs, c_used, c_dest, c_wb, c_mr, r_fwd, r_frz, r_fl);
    end
    rst_n = 1'b1;
    applyStimulus(1'b0, 0, 0, 0, 3'b000, 0, 0, 0, 1, 0, 0);

    // Saturation: issue every (SAT_LAT+1)th cycle, stall otherwise.
    checkValue("sat_reset", {16'd0, sat_stall_count}, 32'd0);
    sat_rst_n = 1'b1;
    repeat (40000) @(posedge clk);
    @(negedge clk);
    checkValue("sat_mid", {16'd0, sat_stall_count}, 32'(40000 - (40000 + SAT_LAT) / (SAT_LAT + 1)));
    checkValue("sat_mid_hazard", {31'd0, sat_hazard}, 32'd1);
    repeat (25558) @(posedge clk);
    @(negedge clk);
    checkValue("sat_full", {16'd0, sat_stall_count}, 32'h0000_FFFF);
    checkValue("sat_full_issue", {31'd0, sat_issue}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
